pc_unit: RTL

Parametrised next-generation program counter for the single-cycle MIPS core. It replaces the bare PC register and the external next-PC mux. The block owns the PC register and the next-PC selection, covering sequential, branch, jump, jump-register and exception redirects, with stall support. It adds a circular return-address stack (RAS) that predicts `jr $ra` targets and flags mispredictions.

---
 rtl/pc_unit.sv | 75 +++++++
 1 files changed

// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC selection, stall/exception redirect and a circular return-address stack
module pc_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0180,
  parameter int RAS_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exception,
  input  logic             branch_taken,
  input  logic [15:0]      imm,
  input  logic             jump,
  input  logic             jump_link,
  input  logic [25:0]      target,
  input  logic             jump_reg,
  input  logic [XLEN-1:0]  jr_target,
  input  logic             ret,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic [XLEN-1:0]  ras_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             mispredict,
  output logic [CNT_W-1:0] mispredict_count
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   ptr, top_idx;
  logic [PW:0]     occ;
  logic [XLEN-1:0] br_addr, j_addr, next_pc;
  logic            advance, push, pop, miss;
  always_comb begin
    pc_plus4  = pc + XLEN'(4);
    br_addr   = pc_plus4 + {{(XLEN-18){imm[15]}}, imm, 2'b00};
    j_addr    = {pc_plus4[XLEN-1:28], target, 2'b00};
    next_pc   = exception ? EXC_VECTOR :
                stall ? pc :
                jump_reg ? jr_target :
                jump ? j_addr :
                branch_taken ? br_addr : pc_plus4;
    advance   = !exception && !stall;
    push      = advance && jump && jump_link && !jump_reg;
    pop       = advance && jump_reg && ret;
    ras_empty = occ == '0;
    ras_full  = occ == (PW+1)'(RAS_DEPTH);
    top_idx   = ptr - PW'(1);
    ras_top   = ras_empty ? '0 : ras[top_idx];
    miss      = pop && (ras_empty || ras_top != jr_target);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc               <= RESET_VECTOR;
      ptr              <= '0;
      occ              <= '0;
      mispredict       <= 1'b0;
      mispredict_count <= '0;
    end else begin
      pc         <= next_pc;
      mispredict <= miss;
      if (miss && !(&mispredict_count)) mispredict_count <= mispredict_count + CNT_W'(1);
      if (push) begin
        ptr <= ptr + PW'(1);
        occ <= ras_full ? occ : occ + (PW+1)'(1);
      end else if (pop && !ras_empty) begin
        ptr <= top_idx;
        occ <= occ - (PW+1)'(1);
      end
    end
  // entries carry no reset; occupancy alone decides validity
  always_ff @(posedge clk)
    if (push) ras[ptr] <= pc_plus4;
endmodule
